// File: rtl/matmul_stream_ctrl_if.sv
// matmul_stream_ctrl_if: valid/ready/data stream carrying operand words in and result words out.
interface matmul_stream_ctrl_if #(parameter int DATA_WIDTH = 32);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    modport master (output valid, data, input ready);
    modport slave (input valid, data, output ready);
endinterface

// File: rtl/matmul_stream_ctrl.sv
// matmul_stream_ctrl: loads A/B from a stream, kicks the multiplier, drains C row-major as a stream.
// Define MATMUL_STREAM_CHECKSUM_EN to accumulate a checksum of the drained result words.
module matmul_stream_ctrl #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    matmul_stream_ctrl_if.slave   operand,
    output logic [DATA_WIDTH-1:0] a_din,
    output logic [ADDR_WIDTH-1:0] a_wr_addr,
    output logic                  a_wr_en,
    output logic [DATA_WIDTH-1:0] b_din,
    output logic [ADDR_WIDTH-1:0] b_wr_addr,
    output logic                  b_wr_en,
    output logic                  mm_start,
    input  logic                  mm_done,
    output logic [ADDR_WIDTH-1:0] c_rd_addr,
    input  logic [DATA_WIDTH-1:0] c_dout,
    matmul_stream_ctrl_if.master  result,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);
    localparam int IW = ADDR_WIDTH + 1;
    localparam logic [IW-1:0] LAST = IW'(N * N - 1);

    typedef enum logic [3:0] {IDLE, LOAD_A, LOAD_B, START, WAIT, RD, CAP, HOLD, FIN} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          accept;
    logic          last;

    assign accept    = operand.valid && operand.ready;
    assign last      = idx == LAST;
    assign a_wr_en   = accept && state == LOAD_A;
    assign b_wr_en   = accept && state == LOAD_B;
    assign a_din     = a_wr_en ? operand.data : '0;
    assign b_din     = b_wr_en ? operand.data : '0;
    assign a_wr_addr = idx[ADDR_WIDTH-1:0];
    assign b_wr_addr = idx[ADDR_WIDTH-1:0];
    assign c_rd_addr = idx[ADDR_WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            operand.ready <= 1'b0;
            result.valid  <= 1'b0;
            result.data   <= '0;
            mm_start      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state         <= LOAD_A;
                    busy          <= 1'b1;
                    operand.ready <= 1'b1;
                end
                LOAD_A: if (accept) begin
                    idx   <= last ? '0 : idx + IW'(1);
                    state <= last ? LOAD_B : LOAD_A;
                end
                LOAD_B: if (accept) begin
                    idx           <= last ? '0 : idx + IW'(1);
                    state         <= last ? START : LOAD_B;
                    operand.ready <= !last;
                    mm_start      <= last;
                end
                START: begin
                    mm_start <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: if (mm_done) state <= RD;
                RD: state <= CAP;
                // c_dout now reflects the address presented during RD
                CAP: begin
                    result.data  <= c_dout;
                    result.valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: if (result.ready) begin
                    result.valid <= 1'b0;
                    idx          <= last ? '0 : idx + IW'(1);
                    state        <= last ? FIN : RD;
                    done         <= last;
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MATMUL_STREAM_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) checksum <= '0;
        else if (state == IDLE && go) checksum <= '0;
        else if (state == HOLD && result.ready) checksum <= checksum + result.data;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// tb_matmul_stream_ctrl: scoreboard bench with memory and multiplier models around the controller.
module tb_matmul_stream_ctrl;
    localparam int N = 2, DW = 32, AW = 4, NN = N * N;

    typedef struct {
        bit            b;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clock = 0, reset = 1, go = 0, mm_tie = 0, mm_fin = 0;
    logic [DW-1:0] a_din, b_din, c_dout, checksum, acc;
    logic [AW-1:0] a_wr_addr, b_wr_addr, c_rd_addr;
    logic a_wr_en, b_wr_en, mm_start, mm_done, busy, done, done_q = 0;
    logic [DW-1:0] amem [2**AW], bmem [2**AW], cmem [2**AW];
    logic [DW-1:0] sa [NN], sb [NN];
    int checks = 0, failures = 0, nwr = 0, mm_starts = 0, done_cnt = 0, mm_cnt = 0;
    wr_t wq [$];
    logic [DW-1:0] oq [$];
    wr_t e;
    logic [DW-1:0] eo;

    matmul_stream_ctrl_if #(.DATA_WIDTH(DW)) operand ();
    matmul_stream_ctrl_if #(.DATA_WIDTH(DW)) result ();

    matmul_stream_ctrl #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .go(go), .operand(operand),
        .a_din(a_din), .a_wr_addr(a_wr_addr), .a_wr_en(a_wr_en),
        .b_din(b_din), .b_wr_addr(b_wr_addr), .b_wr_en(b_wr_en),
        .mm_start(mm_start), .mm_done(mm_done), .c_rd_addr(c_rd_addr), .c_dout(c_dout),
        .result(result), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (a_wr_en) amem[a_wr_addr] <= a_din;
        if (b_wr_en) bmem[b_wr_addr] <= b_din;
        c_dout <= cmem[c_rd_addr];
    end

    // multiplier model: computes C from the memories and raises done a few cycles later
    always @(posedge clock) begin
        if (mm_start) begin
            mm_starts++;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc = '0;
                    for (int k = 0; k < N; k++) acc += amem[i*N+k] * bmem[k*N+j];
                    cmem[i*N+j] <= acc;
                end
            mm_cnt <= 3;
            mm_fin <= 0;
        end else if (mm_cnt > 0) begin
            mm_cnt <= mm_cnt - 1;
            if (mm_cnt == 1) mm_fin <= 1;
        end
    end
    assign mm_done = mm_tie | mm_fin;

    always @(negedge clock) begin
        if (!reset) begin
            if (a_wr_en || b_wr_en) begin
                nwr++;
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected a_en=%0b b_en=%0b", a_wr_en, b_wr_en);
                end else begin
                    e = wq.pop_front();
                    if ({a_wr_en, b_wr_en} !== {!e.b, e.b} || !operand.valid ||
                        (e.b ? b_wr_addr : a_wr_addr) !== e.addr || (e.b ? b_din : a_din) !== e.data) begin
                        failures++;
                        $display("FAIL write got a_en=%0b b_en=%0b valid=%0b addr=%0d data=%0d want b=%0b addr=%0d data=%0d",
                                 a_wr_en, b_wr_en, operand.valid, e.b ? b_wr_addr : a_wr_addr,
                                 e.b ? b_din : a_din, e.b, e.addr, e.data);
                    end
                end
            end
            if (result.valid && result.ready) begin
                checks++;
                if (oq.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected got=%0d", result.data);
                end else begin
                    eo = oq.pop_front();
                    if (result.data !== eo) begin
                        failures++;
                        $display("FAIL out_data got=%0d want=%0d", result.data, eo);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                if (done_q) begin
                    checks++;
                    failures++;
                    $display("FAIL done_width got two-cycle pulse want one cycle");
                end
            end
        end
        done_q = done;
    end

    function automatic logic [DW-1:0] mm_ref(input int i, input int j);
        logic [DW-1:0] s = '0;
        for (int k = 0; k < N; k++) s += sa[i*N+k] * sb[k*N+j];
        return s;
    endfunction

    task automatic send(input logic [DW-1:0] d, input int gap);
        int t = 0;
        logic ok = 0;
        operand.valid = 1;
        operand.data = d;
        while (!ok && t < 50) begin
            @(negedge clock);
            ok = operand.ready;
            @(posedge clock);
            #1;
            t++;
        end
        operand.valid = 0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got ready=0 want ready=1 within 50 cycles");
        end
        if (gap != 0) begin
            operand.data = $urandom;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_go();
        go = 1;
        @(posedge clock);
        #1;
        go = 0;
    endtask

    task automatic run_job(input int gap, input int stall);
        int t, w0, s0, d0;
        logic [DW-1:0] hd, exp_sum;
        logic [AW-1:0] ha;
        exp_sum = '0;
        for (int k = 0; k < NN; k++) wq.push_back('{1'b0, AW'(k), sa[k]});
        for (int k = 0; k < NN; k++) wq.push_back('{1'b1, AW'(k), sb[k]});
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                oq.push_back(mm_ref(i, j));
                exp_sum += mm_ref(i, j);
            end
        w0 = nwr; s0 = mm_starts; d0 = done_cnt;
        result.ready = (stall == 0);
        pulse_go();
        checks++;
        if (busy !== 1 || operand.ready !== 1) begin
            failures++;
            $display("FAIL job_begin got busy=%0b in_ready=%0b want 1/1", busy, operand.ready);
        end
        go = (gap != 0);
        for (int k = 0; k < NN; k++) send(sa[k], gap);
        for (int k = 0; k < NN; k++) send(sb[k], gap);
        go = 0;
        if (stall != 0) begin
            t = 0;
            while (!result.valid && t < 100) begin
                @(posedge clock);
                #1;
                t++;
            end
            hd = result.data;
            ha = c_rd_addr;
            for (int c = 0; c < 10; c++) begin
                @(posedge clock);
                #1;
                checks++;
                if (result.valid !== 1 || result.data !== hd || c_rd_addr !== ha) begin
                    failures++;
                    $display("FAIL hold_stable got valid=%0b data=%0d addr=%0d want 1/%0d/%0d",
                             result.valid, result.data, c_rd_addr, hd, ha);
                end
            end
            result.ready = 1;
        end
        t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(posedge clock);
            #1;
            t++;
        end
        checks++;
        if (done_cnt - d0 != 1 || busy !== 0) begin
            failures++;
            $display("FAIL job_end got done_pulses=%0d busy=%0b want 1/0", done_cnt - d0, busy);
        end
        checks++;
        if (nwr - w0 != 2 * NN || wq.size() != 0) begin
            failures++;
            $display("FAIL write_count got=%0d pending=%0d want=%0d pending=0", nwr - w0, wq.size(), 2 * NN);
        end
        checks++;
        if (mm_starts - s0 != 1) begin
            failures++;
            $display("FAIL mm_start_count got=%0d want=1", mm_starts - s0);
        end
        checks++;
        if (oq.size() != 0) begin
            failures++;
            $display("FAIL out_count got pending=%0d want 0", oq.size());
        end
`ifndef MATMUL_STREAM_CHECKSUM_EN
        exp_sum = '0;
`endif
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (checksum !== exp_sum) begin
            failures++;
            $display("FAIL checksum got=%0d want=%0d", checksum, exp_sum);
        end
        wq.delete();
        oq.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({busy, done, operand.ready, result.valid, mm_start, a_wr_en, b_wr_en} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {busy, done, operand.ready, result.valid, mm_start, a_wr_en, b_wr_en});
        end
        checks++;
        if (result.data !== 0 || checksum !== 0) begin
            failures++;
            $display("FAIL reset_data got out=%0d sum=%0d want 0/0", result.data, checksum);
        end
        checks++;
        if ({a_wr_addr, b_wr_addr, c_rd_addr} !== '0) begin
            failures++;
            $display("FAIL reset_addr got a=%0d b=%0d c=%0d want 0", a_wr_addr, b_wr_addr, c_rd_addr);
        end
        reset = 0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (busy !== 0 || operand.ready !== 0) begin
            failures++;
            $display("FAIL idle_without_go got busy=%0b in_ready=%0b want 0/0", busy, operand.ready);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < NN; k++) begin
            sa[k] = DW'(k + 1);
            sb[k] = DW'(k + 5);
        end
        run_job(0, 0);
    endtask

    task automatic test_gapped_load();
        for (int k = 0; k < NN; k++) begin
            sa[k] = $urandom_range(0, 1000);
            sb[k] = $urandom_range(0, 1000);
        end
        run_job(1, 0);
    endtask

    task automatic test_hold_stall();
        for (int k = 0; k < NN; k++) begin
            sa[k] = $urandom_range(1, 500);
            sb[k] = $urandom_range(1, 500);
        end
        run_job(0, 1);
    endtask

    task automatic test_mm_done_early();
        for (int k = 0; k < NN; k++) begin
            sa[k] = $urandom_range(0, 300);
            sb[k] = $urandom_range(0, 300);
        end
        mm_tie = 1;
        run_job(0, 0);
        mm_tie = 0;
    endtask

    task automatic test_reset_abort();
        for (int k = 0; k < NN; k++) begin
            sa[k] = $urandom_range(0, 99);
            sb[k] = $urandom_range(0, 99);
            wq.push_back('{1'b0, AW'(k), sa[k]});
        end
        for (int k = 0; k < 3; k++) wq.push_back('{1'b1, AW'(k), sb[k]});
        pulse_go();
        for (int k = 0; k < NN; k++) send(sa[k], 0);
        for (int k = 0; k < 3; k++) send(sb[k], 0);
        operand.valid = 1;
        operand.data = 32'hDEAD;
        reset = 1;
        #1;
        checks++;
        if (busy !== 0 || operand.ready !== 0 || a_wr_en !== 0 || b_wr_en !== 0 || mm_start !== 0) begin
            failures++;
            $display("FAIL abort got busy=%0b in_ready=%0b a_en=%0b b_en=%0b mm_start=%0b want all 0",
                     busy, operand.ready, a_wr_en, b_wr_en, mm_start);
        end
        @(posedge clock);
        #1;
        checks++;
        if (a_wr_en !== 0 || b_wr_en !== 0 || operand.ready !== 0) begin
            failures++;
            $display("FAIL abort_hold got a_en=%0b b_en=%0b in_ready=%0b want 0", a_wr_en, b_wr_en, operand.ready);
        end
        reset = 0;
        operand.valid = 0;
        checks++;
        if (wq.size() != 0) begin
            failures++;
            $display("FAIL abort_writes got pending=%0d want 0", wq.size());
        end
        wq.delete();
        @(posedge clock);
        #1;
        test_basic();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NN; k++) begin
                sa[k] = $urandom;
                sb[k] = $urandom;
            end
            run_job(r, 0);
        end
    endtask

    initial begin
        operand.valid = 0;
        operand.data = '0;
        result.ready = 1;
        test_reset();
        test_basic();
        test_gapped_load();
        test_hold_stall();
        test_mm_done_early();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/matmul_stream_ctrl.md
MATMUL_STREAM_CTRL -- requirements
Module: matmul_stream_ctrl

Interface
- REQ-001: Parameter N, default 8; matrix dimension (N x N operands and result).
- REQ-002: Parameter DATA_WIDTH, default 32; element width.
- REQ-003: Parameter ADDR_WIDTH, default 6; memory address width, SHALL satisfy 2^ADDR_WIDTH >= N*N.
- REQ-004: clock  input  1  rising-edge clock for all state.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: go  input  1  pulse in IDLE begins a load/compute/drain job.
- REQ-007: in_valid, in_ready, in_data  input/output/input  1/1/DATA_WIDTH  operand stream, A row-major then B row-major.
- REQ-008: a_din, a_wr_addr, a_wr_en  output  DATA_WIDTH/ADDR_WIDTH/1  A memory write port.
- REQ-009: b_din, b_wr_addr, b_wr_en  output  DATA_WIDTH/ADDR_WIDTH/1  B memory write port.
- REQ-010: mm_start, mm_done  output/input  1/1  multiplier start pulse and done level.
- REQ-011: c_rd_addr, c_dout  output/input  ADDR_WIDTH/DATA_WIDTH  C memory read port; c_dout is valid one cycle after c_rd_addr.
- REQ-012: out_valid, out_ready, out_data  output/input/output  1/1/DATA_WIDTH  result stream, row-major.
- REQ-013: busy, done  output  1/1  busy is high outside IDLE; done is a one-cycle pulse at job end.

Function
- REQ-014: States SHALL be IDLE, LOAD_A, LOAD_B, START, WAIT, RD, CAP, HOLD, FIN.
- REQ-015: IDLE -> LOAD_A on go=1; go outside IDLE SHALL be ignored.
- REQ-016: in_ready SHALL be 1 only in LOAD_A/LOAD_B; an accept is in_valid&&in_ready.
- REQ-017: On an accept in LOAD_A, a_wr_en=1, a_wr_addr=idx, a_din=in_data in the same cycle (combinational); same for B in LOAD_B.
- REQ-018: idx is ADDR_WIDTH+1 bits, increments per accept, and clears when leaving LOAD_A, LOAD_B and HOLD; LOAD_A -> LOAD_B and LOAD_B -> START follow the accept with idx==N*N-1.
- REQ-019: START SHALL assert mm_start for exactly one cycle, then go to WAIT.
- REQ-020: WAIT -> RD when mm_done==1; mm_done SHALL be sampled only in WAIT.
- REQ-021: RD drives c_rd_addr=idx; CAP registers c_dout into out_data and sets out_valid=1; then HOLD.
- REQ-022: In HOLD, out_valid and out_data SHALL stay stable until out_ready=1.
- REQ-023: On accept in HOLD: out_valid=0 next cycle; if idx==N*N-1 go to FIN, else idx+1 and go to RD.
- REQ-024: FIN asserts done for one cycle, then IDLE.
- REQ-025: Write enables and mm_start SHALL never be high outside their states; at most one of a_wr_en/b_wr_en is high per cycle.

Reset
- REQ-026: On reset, state=IDLE, idx=0, and all outputs 0 (busy, done, in_ready, out_valid, out_data, mm_start, write enables, addresses).
- REQ-027: Reset mid-job SHALL abort immediately with no further memory writes; partial memory contents are not restored.

Configuration
- REQ-028: With MATMUL_STREAM_CHECKSUM_EN defined, output checksum[DATA_WIDTH-1:0] SHALL hold the mod-2^DATA_WIDTH sum of all out_data words accepted in the current job, clear on go, and be stable from FIN until the next go.
- REQ-029: Without MATMUL_STREAM_CHECKSUM_EN, the checksum port SHALL exist and be tied to 0, with no accumulator logic.

Verification
- REQ-030: N=2; go; stream A=1,2,3,4 then B=5,6,7,8 -> A/B writes at addrs 0..3, one mm_start pulse, model C -> out_data 19,22,43,50, then done pulse.
- REQ-031: in_valid toggling every other cycle during load -> exactly 2*N*N writes, addresses contiguous, no write while in_valid=0.
- REQ-032: out_ready held 0 for 10 cycles in HOLD -> out_valid stays 1, out_data unchanged, c_rd_addr unchanged.
- REQ-033: mm_done tied high during load -> no effect until WAIT; mm_start pulses exactly once.
- REQ-034: Reset asserted in LOAD_B after 3 B words -> next cycle state IDLE, in_ready=0, busy=0; a fresh go runs a full job correctly.
- REQ-035: With MATMUL_STREAM_CHECKSUM_EN, the REQ-030 job -> checksum=134 after FIN; without it, checksum=0.
